// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
// Sequences 3x3 windows of a latched image through a shared external MAC.
// Windows are issued under credit-based flow control. Results are buffered
// in a small FIFO and streamed out with a valid/ready handshake.
//
// Build option: define CONV_ZERO_PAD_EN for same-size output.
// The window origin then spans -1..IMG_W-2, and out-of-image slots read as 0.
// Without the macro, only fully in-image windows are issued.
module conv_window_scheduler #(
    parameter int IMG_W      = 8,
    parameter int PW         = 2,
    parameter int RW         = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [IMG_W*IMG_W*PW-1:0] in,
    input  logic [9*PW-1:0]           filter,
    output logic                      busy,
    output logic                      done,
    output logic                      win_valid,
    output logic [9*PW-1:0]           win_data,
    output logic [9*PW-1:0]           win_filter,
    input  logic                      mac_valid,
    input  logic [RW-1:0]             mac_result,
    output logic                      res_valid,
    output logic [RW-1:0]             res_data,
    input  logic                      res_ready
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(IMG_W) + 1;

`ifdef CONV_ZERO_PAD_EN
    localparam logic signed [IW-1:0] POS_MIN = IW'(-1);
    localparam logic signed [IW-1:0] POS_MAX = IW'(IMG_W - 2);
`else
    localparam logic signed [IW-1:0] POS_MIN = '0;
    localparam logic signed [IW-1:0] POS_MAX = IW'(IMG_W - 3);
`endif

    localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                    state;
    logic [IMG_W*IMG_W*PW-1:0] img;
    logic signed [IW-1:0]      row;
    logic signed [IW-1:0]      col;
    logic [CW-1:0]             inflight;
    logic [CW-1:0]             fifo_count;
    logic [AW-1:0]             wptr;
    logic [AW-1:0]             rptr;
    logic [RW-1:0]             mem [FIFO_DEPTH];
    logic                      issue;
    logic                      mac_accept;
    logic                      fifo_rd;
    logic [9*PW-1:0]           win_next;

    // Fetch one pixel of the latched image; off-image reads return 0 when padding.
    function automatic logic [PW-1:0] pixel_at(
        input logic [IMG_W*IMG_W*PW-1:0] im,
        input int                        rr,
        input int                        cc
    );
`ifdef CONV_ZERO_PAD_EN
        pixel_at = '0;
        if (rr >= 0 && rr < IMG_W && cc >= 0 && cc < IMG_W)
            pixel_at = im[(rr*IMG_W + cc)*PW +: PW];
`else
        pixel_at = im[(rr*IMG_W + cc)*PW +: PW];
`endif
    endfunction

    // Gather the 3x3 window at the current (row, col) origin in filter packing.
    always_comb begin
        win_next = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_next[(i*3 + j)*PW +: PW] = pixel_at(img, int'(row) + i, int'(col) + j);
            end
        end
    end

    // A window may issue only while every outstanding result has a FIFO slot reserved.
    always_comb begin
        issue      = (state == RUN) &&
                     (({1'b0, inflight} + {1'b0, fifo_count}) < CREDITS);
        mac_accept = mac_valid && (inflight != '0);
        res_valid  = (fifo_count != '0);
        fifo_rd    = res_valid && res_ready;
        res_data   = mem[rptr];
    end

    // Track windows handed to the MAC whose results have not come back yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(mac_accept);
        end
    end

    // Result FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (mac_accept)
                wptr <= wptr + AW'(1);
            if (fifo_rd)
                rptr <= rptr + AW'(1);
            fifo_count <= fifo_count + CW'(mac_accept) - CW'(fifo_rd);
        end
    end

    // Result FIFO storage; contents are only visible through occupancy, so no reset.
    always_ff @(posedge clk) begin
        if (mac_accept)
            mem[wptr] <= mac_result;
    end

    // Control FSM: latch operands, walk the windows, wait for drain, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            win_filter <= '0;
            img        <= '0;
            row        <= '0;
            col        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    win_valid <= 1'b0;
                    if (start) begin
                        img        <= in;
                        win_filter <= filter;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    row   <= POS_MIN;
                    col   <= POS_MIN;
                    state <= RUN;
                end
                RUN: begin
                    if (issue) begin
                        win_valid <= 1'b1;
                        win_data  <= win_next;
                        if (col == POS_MAX) begin
                            col <= POS_MIN;
                            if (row == POS_MAX)
                                state <= DRAIN;
                            else
                                row <= row + IW'(1);
                        end else begin
                            col <= col + IW'(1);
                        end
                    end else begin
                        win_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    win_valid <= 1'b0;
                    if (inflight == '0 && fifo_count == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    win_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
